fnd_controller: RTL
===================

// Module: fnd_controller
// PURPOSE
//  Downstream display stage for the 0..9999 counter: takes the binary count value and
//  drives a 4-digit common-anode 7-segment FND by time-multiplexed scanning.
//  Performs digit split (BCD), 7-seg encode, optional leading-zero blanking, DP control.
//  Outputs connect directly to board pins fnd_data/fnd_com.
// PARAMETERS
//  CLK_FREQ  100_000_000  input clock frequency in Hz
//  SCAN_HZ   1000         digit-advance rate in Hz; SCAN_DIV = CLK_FREQ/SCAN_HZ (>=2)
// PORTS
//  clk       in   1   system clock
//  reset     in   1   synchronous, active-high reset
//  count     in   14  binary value to display (0..16383 accepted)
//  blank_lz  in   1   1 = blank leading zeros
//  dp_mask   in   4   bit i = light decimal point of digit i (digit 0 = ones)
//  fnd_data  out  8   segments, active low, {dp,g,f,e,d,c,b,a}
//  fnd_com   out  4   digit commons, active low, bit i = digit i
// BEHAVIOUR
//  - Prescaler: 0..SCAN_DIV-1. tick = (prescaler==SCAN_DIV-1). On tick, prescaler->0
//    and sel (2 bit) increments, wrapping 3->0. Each digit is active for SCAN_DIV clocks.
//  - Snapshot: register snap loads count on the edge where tick && sel==3, i.e. the
//    start of a frame. This prevents tearing, so a frame never mixes two values.
//  - Saturation: if snap > 9999, the displayed value is 9999.
//  - Digit split: d0=v%10, d1=(v/10)%10, d2=(v/100)%10, d3=v/1000. The split can be
//    combinational from snap or registered at the snapshot point, but the output timing
//    below is mandatory.
//  - Encode: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (hex, dp bit off).
//    If dp_mask[sel]=1, bit7 is cleared (e.g. 1 with dp -> 79).
//  - Blanking (blank_lz=1): d3 blank if 0; d2 blank if d3,d2 both 0; d1 blank if d3..d1
//    all 0; d0 never blank. A blanked digit drives segments FF; dp_mask still applies.
//    Its com stays active.
//  - Outputs are registered from the current sel/snap/dp_mask/blank_lz, so fnd_com and
//    fnd_data change exactly 1 clock after sel changes. fnd_com = ~(4'b0001<<sel).
//  - Reset (synchronous): prescaler=0, sel=0, snap=0, fnd_com=4'b1111, fnd_data=8'hFF.
//    At the first edge with reset=0: fnd_com=4'b1110, fnd_data=C0 (value 0, digit 0).
//  - Reset mid-frame: same as above. Scanning restarts at digit 0 and snap is cleared.
//  - dp_mask and blank_lz are sampled live, not snapshotted.
//  - No combinational path from any input to any output.
// TESTING  (bench: CLK_FREQ=1000, SCAN_HZ=250 -> SCAN_DIV=4, 10 ns clock)
//  1 Reset: while reset=1, fnd_com=1111 and fnd_data=FF. First edge after release gives
//    fnd_com=1110 and fnd_data=C0; the first tick follows 4 clocks later.
//  2 count=1234, blank_lz=0, dp_mask=0: the frame must show 1110/99, 1101/B0, 1011/A4,
//    0111/F9, each held for exactly 4 clocks, then wrap to 1110.
//  3 Snapshot: count changes 1234->5678 while digit 1 is active. Digits 2,3 must still
//    show A4,F9. The next frame must show 80,F8,82,92.
//  4 blank_lz=1: count=7 -> digit0 F8, digits 1-3 FF with their com low.
//    count=0 -> digit0 C0. count=1005 -> digits 92,C0,C0,F9 (no blanking).
//  5 count=12000 -> all four digits show 90 (9999 saturation).
//  6 count=1234 with dp_mask=0100 -> digit2 shows 24, other digits unchanged. Asserting
//    reset during digit 2 -> next edge gives 1111/FF; after release, scanning restarts
//    at 1110/C0.

Source files
------------

// File: rtl/fnd_controller.sv
// fnd_controller: scans a 4-digit common-anode 7-seg FND from a 0..9999 count,
// with frame-level snapshotting, 9999 saturation, leading-zero blanking and DP control.
module fnd_controller #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] count,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [7:0]  fnd_data,
    output logic [3:0]  fnd_com
);
    localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    sel;
    logic [13:0]   snap;
    logic [13:0]   val;
    logic [15:0]   bcd;
    logic [3:0]    dig;
    logic [3:0]    blank;
    logic [6:0]    seg;
    logic          lz3;
    logic          tick;

    function automatic logic [15:0] to_bcd(input logic [13:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int k = 0; k < 4; k++)
                if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
            r = {r[14:0], b[i]};
        end
        return r;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h40;
            4'd1: enc = 7'h79;
            4'd2: enc = 7'h24;
            4'd3: enc = 7'h30;
            4'd4: enc = 7'h19;
            4'd5: enc = 7'h12;
            4'd6: enc = 7'h02;
            4'd7: enc = 7'h78;
            4'd8: enc = 7'h00;
            4'd9: enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    assign tick  = presc == PW'(SCAN_DIV - 1);
    assign val   = (snap > 14'd9999) ? 14'd9999 : snap;
    assign bcd   = to_bcd(val);
    assign dig   = bcd[{sel, 2'b00} +: 4];
    assign seg   = enc(dig);
    // a digit blanks only when every more-significant digit is blank too
    assign lz3   = blank_lz & ~|bcd[15:12];
    assign blank = {lz3, lz3 & ~|bcd[11:8], lz3 & ~|bcd[11:8] & ~|bcd[7:4], 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            sel      <= '0;
            snap     <= '0;
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            sel      <= sel + 2'(tick);
            if (tick && sel == 2'd3) snap <= count;
            fnd_com  <= ~(4'b0001 << sel);
            fnd_data <= {~dp_mask[sel], blank[sel] ? 7'h7F : seg};
        end
    end
endmodule
